// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : RV32I fetch stage: owns the PC, issues credit-limited in-order
//            imem reads, squashes wrong-path fetches on redirect and buffers
//            returned instructions for decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic [6:0]  op_code,
    output logic [2:0]  func3,
    output logic [6:0]  func7
);

    localparam int              c_PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_CW    = 5;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_ZERO  = '0;
    localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);
    localparam logic [c_PW-1:0] c_LAST  = c_PW'(DEPTH - 1);

    function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
        return (p == c_LAST) ? '0 : p + c_PW'(1);
    endfunction

    logic [31:0]     r_fetch_pc;
    logic [c_CW-1:0] r_outstanding;
    logic [c_CW-1:0] r_drop_cnt;
    logic [c_CW-1:0] r_count;
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_PW-1:0] r_aq_head;
    logic [c_PW-1:0] r_aq_tail;
    logic [31:0]     r_fifo_instr [DEPTH];
    logic [31:0]     r_fifo_pc    [DEPTH];
    logic [31:0]     r_aq_pc      [DEPTH];

    logic [c_CW-1:0] w_used;
    logic            w_req_valid;
    logic            w_accept;
    logic            w_rsp_keep;
    logic            w_out_valid;
    logic            w_pop;
    logic [c_CW-1:0] w_acc_inc;
    logic [c_CW-1:0] w_rsp_dec;
    logic [c_CW-1:0] w_keep_inc;
    logic [c_CW-1:0] w_pop_dec;
    logic            w_unused_tgt_lsbs;

    assign w_used      = r_outstanding + r_count;
    assign w_req_valid = !rst && !redirect && (w_used < c_DEPTH);
    assign w_accept    = w_req_valid && imem_req_ready;
    assign w_rsp_keep  = imem_rsp_valid && (r_drop_cnt == c_ZERO) && !redirect;
    assign w_out_valid = (r_count != c_ZERO) && !rst;
    assign w_pop       = w_out_valid && out_ready;

    assign w_acc_inc  = {{(c_CW-1){1'b0}}, w_accept};
    assign w_rsp_dec  = {{(c_CW-1){1'b0}}, imem_rsp_valid};
    assign w_keep_inc = {{(c_CW-1){1'b0}}, w_rsp_keep};
    assign w_pop_dec  = {{(c_CW-1){1'b0}}, w_pop};

    assign w_unused_tgt_lsbs = &{1'b0, redirect_target[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_aq_head     <= '0;
            r_aq_tail     <= '0;
        end else if (redirect) begin
            r_fetch_pc    <= {redirect_target[31:2], 2'b00};
            r_count       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_aq_head     <= '0;
            r_aq_tail     <= '0;
            r_outstanding <= r_outstanding - w_rsp_dec;
            // Every fetch still in flight is wrong-path now; outstanding already
            // includes responses owed to earlier redirects, so it is the total.
            r_drop_cnt    <= r_outstanding - w_rsp_dec;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_aq_tail  <= f_next(r_aq_tail);
            end
            if (imem_rsp_valid && (r_drop_cnt != c_ZERO)) begin
                r_drop_cnt <= r_drop_cnt - c_ONE;
            end
            if (w_rsp_keep) begin
                r_tail    <= f_next(r_tail);
                r_aq_head <= f_next(r_aq_head);
            end
            if (w_pop) begin
                r_head <= f_next(r_head);
            end
            r_outstanding <= r_outstanding + w_acc_inc - w_rsp_dec;
            r_count       <= r_count + w_keep_inc - w_pop_dec;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_aq_pc[r_aq_tail] <= r_fetch_pc;
        end
        if (w_rsp_keep) begin
            r_fifo_instr[r_tail] <= imem_rsp_data;
            r_fifo_pc[r_tail]    <= r_aq_pc[r_aq_head];
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign out_valid      = w_out_valid;
    assign out_instr      = w_out_valid ? r_fifo_instr[r_head] : 32'd0;
    assign out_pc         = w_out_valid ? r_fifo_pc[r_head] : 32'd0;
    assign out_pc_plus4   = w_out_valid ? (r_fifo_pc[r_head] + 32'd4) : 32'd0;
    assign op_code        = out_instr[6:0];
    assign func3          = out_instr[14:12];
    assign func7          = out_instr[31:25];

endmodule
`default_nettype wire
